mem_port_arbiter: RTL and testbench

//  Shares one memory port among NUM_REQ requesters (A-loader, B-loader, C-writer, ...).

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter_rr_arbiter.sv | 34 +++
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory-port arbiter.
//   arb_state_t : arbiter FSM state (IDLE -> ISSUE -> DONE -> IDLE)
//   DEF_*       : default parameter values used by the interface and top
//   rr_next     : round-robin pointer advance with wrap
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 257;
    localparam int DEF_TIMEOUT = 1024;

    // Index following idx in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester-side and memory-side buses of the arbiter.
//   rq_*        : packed per-requester request fields, ack/err/rdata back
//   m_*         : single memory-slave port
//   grant_id, busy, timeout_err : arbiter status
// Modports:
//   master : arbiter view (drives m_* and rq_ack/rq_err/rq_rdata/status)
//   slave  : environment view (requesters plus memory slave)
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        rq_req;
    logic [NUM_REQ-1:0]        rq_w_en;
    logic [NUM_REQ*ADDR_W-1:0] rq_addr;
    logic [NUM_REQ*DATA_W-1:0] rq_wdata;
    logic [NUM_REQ-1:0]        rq_ack;
    logic                      rq_err;
    logic [DATA_W-1:0]         rq_rdata;

    logic                      m_req;
    logic                      m_w_en;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic                      m_ack;
    logic [DATA_W-1:0]         m_rdata;

    logic [ID_W-1:0]           grant_id;
    logic                      busy;
    logic                      timeout_err;

    modport master (
        input  rq_req, rq_w_en, rq_addr, rq_wdata, m_ack, m_rdata,
        output rq_ack, rq_err, rq_rdata, m_req, m_w_en, m_addr, m_wdata,
        output grant_id, busy, timeout_err
    );

    modport slave (
        output rq_req, rq_w_en, rq_addr, rq_wdata, m_ack, m_rdata,
        input  rq_ack, rq_err, rq_rdata, m_req, m_w_en, m_addr, m_wdata,
        input  grant_id, busy, timeout_err
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req    : request vector
//   ptr    : highest-priority index for this pick
//   valid  : any request present
//   winner : first asserted index at or above ptr, wrapping to 0
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]                               req,
    input  logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] ptr,
    output logic                                             valid,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] winner
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        int idx;
        idx    = 0;
        valid  = 1'b0;
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (req[idx]) begin
                valid  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port among NUM_REQ requesters with
// round-robin arbitration and a single transaction in flight.
// Ports:
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mem_port_arbiter_if.master
//            rq_req/rq_w_en/rq_addr/rq_wdata in, rq_ack/rq_err/rq_rdata out
//            m_req/m_w_en/m_addr/m_wdata out, m_ack/m_rdata in
//            grant_id, busy, timeout_err status out
// All outputs are registered. TIMEOUT = 0 disables the watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input logic                clk,
    input logic                reset,
    mem_port_arbiter_if.master bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit WD_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WD_EN ? TIMEOUT - 1 : 0);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  wd_cnt_q;
    logic              arb_valid;
    logic [ID_W-1:0]   arb_winner;
    logic              ack_fire;
    logic              to_fire;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req    (bus.rq_req),
        .ptr    (ptr_q),
        .valid  (arb_valid),
        .winner (arb_winner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // m_ack wins over a watchdog expiry landing in the same cycle.
    always_comb begin
        state_d  = state_q;
        ack_fire = 1'b0;
        to_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.m_ack) begin
                    ack_fire = 1'b1;
                    state_d  = DONE;
                end else if (WD_EN && (wd_cnt_q == CNT_LAST)) begin
                    to_fire = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q           <= '0;
            wd_cnt_q        <= '0;
            bus.m_req       <= 1'b0;
            bus.m_w_en      <= 1'b0;
            bus.m_addr      <= '0;
            bus.m_wdata     <= '0;
            bus.rq_ack      <= '0;
            bus.rq_err      <= 1'b0;
            bus.rq_rdata    <= '0;
            bus.grant_id    <= '0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            bus.rq_ack <= '0;
            bus.rq_err <= 1'b0;
            bus.busy   <= (state_d != IDLE);
            case (state_q)
                // Latch the winner's fields so later requester changes
                // cannot disturb the in-flight transaction.
                IDLE: begin
                    if (arb_valid) begin
                        bus.grant_id <= arb_winner;
                        ptr_q        <= ID_W'(rr_next(int'(arb_winner), NUM_REQ));
                        bus.m_req    <= 1'b1;
                        bus.m_w_en   <= bus.rq_w_en[arb_winner];
                        bus.m_addr   <= bus.rq_addr[arb_winner*ADDR_W +: ADDR_W];
                        bus.m_wdata  <= bus.rq_wdata[arb_winner*DATA_W +: DATA_W];
                        wd_cnt_q     <= '0;
                    end
                end
                ISSUE: begin
                    if (ack_fire) begin
                        bus.m_req    <= 1'b0;
                        bus.rq_rdata <= bus.m_rdata;
                        bus.rq_ack   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << bus.grant_id;
                    end else if (to_fire) begin
                        bus.m_req       <= 1'b0;
                        bus.rq_err      <= 1'b1;
                        bus.timeout_err <= 1'b1;
                        bus.rq_ack      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << bus.grant_id;
                    end else if (WD_EN) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 257;
    localparam int TIMEOUT = 8;
    localparam int ID_W    = 2;

    localparam logic [DATA_W-1:0] RD1 = {1'b1, {8{32'hCAFE_0001}}};
    localparam logic [DATA_W-1:0] RD2 = {1'b1, {4{64'h0123_4567_89AB_CDEF}}};
    localparam logic [DATA_W-1:0] RD3 = {1'b0, {16{16'h5A5A}}};
    localparam logic [DATA_W-1:0] WD1 = {1'b0, {8{32'h1111_2222}}};
    localparam logic [DATA_W-1:0] WD2 = {1'b1, {8{32'h3333_4444}}};

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.rq_req   = '0;
        bus.rq_w_en  = '0;
        bus.rq_addr  = '0;
        bus.rq_wdata = '0;
        bus.m_ack    = 1'b0;
        bus.m_rdata  = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_rq(input int i, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        bus.rq_w_en[i]                  = w;
        bus.rq_addr[i*ADDR_W +: ADDR_W] = a;
        bus.rq_wdata[i*DATA_W +: DATA_W] = d;
        bus.rq_req[i]                   = 1'b1;
    endtask

    task automatic wait_mreq(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (bus.m_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL rst_m_req got=%0h want=0", bus.m_req); end
        total++; if (bus.m_w_en !== 1'b0) begin bad++; $display("FAIL rst_m_w_en got=%0h want=0", bus.m_w_en); end
        total++; if (bus.m_addr !== '0) begin bad++; $display("FAIL rst_m_addr got=%0h want=0", bus.m_addr); end
        total++; if (bus.m_wdata !== '0) begin bad++; $display("FAIL rst_m_wdata got=%0h want=0", bus.m_wdata); end
        total++; if (bus.rq_ack !== 3'b000) begin bad++; $display("FAIL rst_rq_ack got=%0b want=000", bus.rq_ack); end
        total++; if (bus.rq_err !== 1'b0) begin bad++; $display("FAIL rst_rq_err got=%0h want=0", bus.rq_err); end
        total++; if (bus.rq_rdata !== '0) begin bad++; $display("FAIL rst_rq_rdata got=%0h want=0", bus.rq_rdata); end
        total++; if (bus.grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id got=%0d want=0", bus.grant_id); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", bus.busy); end
        total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_timeout_err got=%0h want=0", bus.timeout_err); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_rq(0, 1'b0, 16'h0010, '0);
        step();
        total++; if (bus.m_req !== 1'b1) begin bad++; $display("FAIL rd_m_req got=%0h want=1", bus.m_req); end
        total++; if (bus.m_addr !== 16'h0010) begin bad++; $display("FAIL rd_m_addr got=%0h want=0010", bus.m_addr); end
        total++; if (bus.m_w_en !== 1'b0) begin bad++; $display("FAIL rd_m_w_en got=%0h want=0", bus.m_w_en); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rd_busy got=%0h want=1", bus.busy); end
        total++; if (bus.rq_ack !== 3'b000) begin bad++; $display("FAIL rd_early_ack got=%0b want=000", bus.rq_ack); end
        bus.m_ack   = 1'b1;
        bus.m_rdata = RD1;
        step();
        bus.m_ack     = 1'b0;
        bus.rq_req[0] = 1'b0;
        total++; if (bus.rq_ack !== 3'b001) begin bad++; $display("FAIL rd_ack got=%0b want=001", bus.rq_ack); end
        total++; if (bus.rq_rdata !== RD1) begin bad++; $display("FAIL rd_rdata got=%0h want=%0h", bus.rq_rdata, RD1); end
        total++; if (bus.rq_err !== 1'b0) begin bad++; $display("FAIL rd_err got=%0h want=0", bus.rq_err); end
        total++; if (bus.m_req !== 1'b0) begin bad++; $display("FAIL rd_m_req_drop got=%0h want=0", bus.m_req); end
        step();
        total++; if (bus.rq_ack !== 3'b000) begin bad++; $display("FAIL rd_ack_pulse got=%0b want=000", bus.rq_ack); end
        total++; if (bus.rq_rdata !== RD1) begin bad++; $display("FAIL rd_rdata_hold got=%0h want=%0h", bus.rq_rdata, RD1); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rd_idle_busy got=%0h want=0", bus.busy); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int exp;
        int acks [NUM_REQ];
        logic [DATA_W-1:0] rd;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            acks[i] = 0;
            set_rq(i, 1'b0, ADDR_W'(16'h0100 + i), '0);
        end
        for (int k = 0; k < 6; k++) begin
            exp = k % NUM_REQ;
            rd  = DATA_W'(k + 32'h77);
            wait_mreq(8, ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_wait k=%0d got=no_m_req want=m_req", k); end
            total++; if (bus.grant_id !== ID_W'(exp)) begin bad++; $display("FAIL rr_grant k=%0d got=%0d want=%0d", k, bus.grant_id, exp); end
            total++; if (bus.m_addr !== ADDR_W'(16'h0100 + exp)) begin bad++; $display("FAIL rr_addr k=%0d got=%0h want=%0h", k, bus.m_addr, 16'h0100 + exp); end
            bus.m_ack   = 1'b1;
            bus.m_rdata = rd;
            step();
            bus.m_ack = 1'b0;
            total++; if (bus.rq_ack !== (NUM_REQ'(1) << exp)) begin bad++; $display("FAIL rr_ack k=%0d got=%0b want=%0b", k, bus.rq_ack, NUM_REQ'(1) << exp); end
            total++; if (bus.rq_rdata !== rd) begin bad++; $display("FAIL rr_rdata k=%0d got=%0h want=%0h", k, bus.rq_rdata, rd); end
            for (int i = 0; i < NUM_REQ; i++) acks[i] += int'(bus.rq_ack[i]);
            step();
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            total++; if (acks[i] != 2) begin bad++; $display("FAIL rr_ack_count req=%0d got=%0d want=2", i, acks[i]); end
        end
        clear_inputs();
        step();
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        set_rq(1, 1'b0, 16'h0201, '0);
        wait_mreq(8, ok);
        total++; if (!ok || bus.grant_id !== 2'd1) begin bad++; $display("FAIL wr_first got=%0d want=1", bus.grant_id); end
        bus.m_ack = 1'b1; step(); bus.m_ack = 1'b0;
        total++; if (bus.rq_ack !== 3'b010) begin bad++; $display("FAIL wr_ack1 got=%0b want=010", bus.rq_ack); end
        set_rq(0, 1'b0, 16'h0200, '0);
        step();
        wait_mreq(8, ok);
        total++; if (!ok || bus.grant_id !== 2'd0) begin bad++; $display("FAIL wr_wrap got=%0d want=0", bus.grant_id); end
        total++; if (bus.m_addr !== 16'h0200) begin bad++; $display("FAIL wr_wrap_addr got=%0h want=0200", bus.m_addr); end
        bus.m_ack = 1'b1; step(); bus.m_ack = 1'b0;
        total++; if (bus.rq_ack !== 3'b001) begin bad++; $display("FAIL wr_ack0 got=%0b want=001", bus.rq_ack); end
        bus.rq_req[0] = 1'b0;
        step();
        wait_mreq(8, ok);
        total++; if (!ok || bus.grant_id !== 2'd1) begin bad++; $display("FAIL wr_second got=%0d want=1", bus.grant_id); end
        bus.m_ack = 1'b1; step(); bus.m_ack = 1'b0;
        total++; if (bus.rq_ack !== 3'b010) begin bad++; $display("FAIL wr_ack1b got=%0b want=010", bus.rq_ack); end
        set_rq(0, 1'b0, 16'h0200, '0);
        set_rq(2, 1'b0, 16'h0202, '0);
        step();
        wait_mreq(8, ok);
        total++; if (!ok || bus.grant_id !== 2'd2) begin bad++; $display("FAIL wr_ptr_end got=%0d want=2", bus.grant_id); end
        bus.m_ack = 1'b1; step(); bus.m_ack = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        bit ok;
        int high;
        do_reset();
        set_rq(0, 1'b1, 16'h0300, WD1);
        step();
        high = 0;
        for (int n = 0; n < 20; n++) begin
            if (bus.m_req !== 1'b1) break;
            high++;
            step();
        end
        total++; if (high != TIMEOUT) begin bad++; $display("FAIL to_mreq_cycles got=%0d want=%0d", high, TIMEOUT); end
        total++; if (bus.rq_ack !== 3'b001) begin bad++; $display("FAIL to_ack got=%0b want=001", bus.rq_ack); end
        total++; if (bus.rq_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0h want=1", bus.rq_err); end
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_flag got=%0h want=1", bus.timeout_err); end
        bus.rq_req = '0;
        bus.m_ack  = 1'b1;
        step();
        bus.m_ack = 1'b0;
        total++; if (bus.rq_ack !== 3'b000) begin bad++; $display("FAIL to_late_ack got=%0b want=000", bus.rq_ack); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%0h want=0", bus.busy); end
        step(); step(); step();
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0h want=1", bus.timeout_err); end
        set_rq(1, 1'b0, 16'h0301, '0);
        wait_mreq(8, ok);
        total++; if (!ok) begin bad++; $display("FAIL to_next_wait got=no_m_req want=m_req"); end
        bus.m_ack   = 1'b1;
        bus.m_rdata = RD3;
        step();
        bus.m_ack = 1'b0;
        total++; if (bus.rq_ack !== 3'b010 || bus.rq_err !== 1'b0) begin bad++; $display("FAIL to_next_ack got=%0b/%0h want=010/0", bus.rq_ack, bus.rq_err); end
        total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky2 got=%0h want=1", bus.timeout_err); end
        clear_inputs();
        step();
    endtask

    task automatic test_write_hold();
        bit stable;
        do_reset();
        set_rq(2, 1'b1, 16'h0ABC, WD1);
        step();
        total++; if (bus.m_req !== 1'b1 || bus.grant_id !== 2'd2) begin bad++; $display("FAIL wh_issue got=%0h/%0d want=1/2", bus.m_req, bus.grant_id); end
        total++; if (bus.m_w_en !== 1'b1) begin bad++; $display("FAIL wh_w_en got=%0h want=1", bus.m_w_en); end
        total++; if (bus.m_wdata !== WD1) begin bad++; $display("FAIL wh_wdata got=%0h want=%0h", bus.m_wdata, WD1); end
        bus.rq_addr[2*ADDR_W +: ADDR_W]  = 16'h0DEF;
        bus.rq_wdata[2*DATA_W +: DATA_W] = WD2;
        bus.rq_w_en[2]                   = 1'b0;
        stable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            step();
            if (bus.m_addr !== 16'h0ABC || bus.m_wdata !== WD1 || bus.m_w_en !== 1'b1 || bus.m_req !== 1'b1)
                stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin bad++; $display("FAIL wh_stable got=%0h/%0h/%0h want=0abc/1/1", bus.m_addr, bus.m_w_en, bus.m_req); end
        bus.m_ack   = 1'b1;
        bus.m_rdata = RD2;
        step();
        bus.m_ack  = 1'b0;
        bus.rq_req = '0;
        total++; if (bus.rq_ack !== 3'b100) begin bad++; $display("FAIL wh_ack got=%0b want=100", bus.rq_ack); end
        total++; if (bus.rq_rdata !== RD2) begin bad++; $display("FAIL wh_rdata got=%0h want=%0h", bus.rq_rdata, RD2); end
        total++; if (bus.rq_err !== 1'b0) begin bad++; $display("FAIL wh_err got=%0h want=0", bus.rq_err); end
        step();
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_rq(1, 1'b1, 16'h1234, WD1);
        step();
        total++; if (bus.m_req !== 1'b1 || bus.grant_id !== 2'd1) begin bad++; $display("FAIL rm_issue got=%0h/%0d want=1/1", bus.m_req, bus.grant_id); end
        clear_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (bus.m_req !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL rm_ctrl got=%0h/%0h want=0/0", bus.m_req, bus.busy); end
        total++; if (bus.m_addr !== '0 || bus.m_wdata !== '0 || bus.m_w_en !== 1'b0) begin bad++; $display("FAIL rm_mbus got=%0h/%0h want=0/0", bus.m_addr, bus.m_w_en); end
        total++; if (bus.grant_id !== 2'd0 || bus.rq_ack !== 3'b000) begin bad++; $display("FAIL rm_grant got=%0d/%0b want=0/000", bus.grant_id, bus.rq_ack); end
        total++; if (bus.rq_rdata !== '0) begin bad++; $display("FAIL rm_rdata got=%0h want=0", bus.rq_rdata); end
        set_rq(0, 1'b0, 16'h0042, '0);
        wait_mreq(8, ok);
        total++; if (!ok || bus.grant_id !== 2'd0 || bus.m_addr !== 16'h0042) begin bad++; $display("FAIL rm_new got=%0d/%0h want=0/0042", bus.grant_id, bus.m_addr); end
        bus.m_ack   = 1'b1;
        bus.m_rdata = RD3;
        step();
        bus.m_ack = 1'b0;
        total++; if (bus.rq_ack !== 3'b001 || bus.rq_rdata !== RD3) begin bad++; $display("FAIL rm_ack got=%0b/%0h want=001/%0h", bus.rq_ack, bus.rq_rdata, RD3); end
        clear_inputs();
        step();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_write_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit got=expired want=finish");
        $fatal(1);
    end

endmodule
